// File: rtl/uart_pkg.sv
// Shared types for the UART receive buffer: FIFO entry layout and drain FSM states.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   ferr;
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible combinationally whenever count is non-zero.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;

    // A pop request against an empty FIFO is ignored.
    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // NOTE: storage is deliberately not reset; count gates visibility, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Drains the UART receiver into a show-ahead FIFO with a one-shot active-low read strobe,
// and keeps saturating parity/frame error counters plus an overrun-risk flag.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk16x,
    input  logic                   clrn,
    input  logic                   r_ready,
    input  logic [UART_DATA_W-1:0] d_out,
    input  logic                   parity_error,
    input  logic                   frame_error,
    output logic                   rdn,
    output logic                   rd_valid,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_perr,
    output logic                   rd_ferr,
    input  logic                   rd_ready,
    output logic [AW:0]            count,
    output logic                   rx_stall,
    output logic [CNT_W-1:0]       perr_cnt,
    output logic [CNT_W-1:0]       ferr_cnt,
    input  logic                   cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    drain_state_t     state_q, state_d;
    logic             rdn_q, rdn_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] perr_cnt_q, perr_cnt_d;
    logic [CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;
    logic             push;
    logic             fifo_full;
    rx_entry_t        wr_entry;
    rx_entry_t        rd_entry;

    assign wr_entry = {frame_error, parity_error, d_out};

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk16x),
        .rst_n   (clrn),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (rd_ready),
        .rdata_o (rd_entry),
        .valid_o (rd_valid),
        .full_o  (fifo_full),
        .count_o (count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (r_ready && !fifo_full) state_d = READ;
            READ: begin
                push    = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (!r_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The strobe is registered: low exactly while the FSM sits in READ.
        rdn_d   = (state_d != READ);
        stall_d = (state_q == IDLE) && r_ready && fifo_full;
    end

    always_comb begin
        perr_cnt_d = perr_cnt_q;
        ferr_cnt_d = ferr_cnt_q;
        if (cnt_clr) begin
            perr_cnt_d = '0;
            ferr_cnt_d = '0;
        end else if (push) begin
            if (parity_error && (perr_cnt_q != CNT_MAX)) perr_cnt_d = perr_cnt_q + 1'b1;
            if (frame_error && (ferr_cnt_q != CNT_MAX))  ferr_cnt_d = ferr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            rdn_q      <= 1'b1;
            stall_q    <= 1'b0;
            perr_cnt_q <= '0;
            ferr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rdn_q      <= rdn_d;
            stall_q    <= stall_d;
            perr_cnt_q <= perr_cnt_d;
            ferr_cnt_q <= ferr_cnt_d;
        end
    end

    assign rdn      = rdn_q;
    assign rx_stall = stall_q;
    assign perr_cnt = perr_cnt_q;
    assign ferr_cnt = ferr_cnt_q;
    assign rd_data  = rd_entry.data;
    assign rd_perr  = rd_entry.perr;
    assign rd_ferr  = rd_entry.ferr;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench: a receiver model drives bytes, a queue plus saturating counters predict the outputs.
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       clrn;
    logic       r_ready;
    logic [7:0] d_out;
    logic       parity_error;
    logic       frame_error;
    logic       rd_ready;
    logic       cnt_clr;

    logic       rdn, rd_valid, rd_perr, rd_ferr, rx_stall;
    logic [7:0] rd_data, perr_cnt, ferr_cnt;
    logic [4:0] count;

    logic       rdn_s, rd_valid_s, rd_perr_s, rd_ferr_s, rx_stall_s;
    logic [7:0] rd_data_s;
    logic [1:0] perr_s, ferr_s;
    logic [4:0] count_s;

    int n_checks = 0;
    int n_fails  = 0;

    logic [9:0] q[$];
    logic [9:0] exp_c[$];
    int perr_m = 0, ferr_m = 0, perr_sm = 0, ferr_sm = 0;

    always #5 clk = ~clk;

    uart_rx_buffer dut (
        .clk16x(clk), .clrn(clrn), .r_ready(r_ready), .d_out(d_out),
        .parity_error(parity_error), .frame_error(frame_error), .rdn(rdn),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .rd_ready(rd_ready), .count(count), .rx_stall(rx_stall),
        .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt), .cnt_clr(cnt_clr)
    );

    uart_rx_buffer #(.CNT_W(2)) dut_sat (
        .clk16x(clk), .clrn(clrn), .r_ready(r_ready), .d_out(d_out),
        .parity_error(parity_error), .frame_error(frame_error), .rdn(rdn_s),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .rd_perr(rd_perr_s), .rd_ferr(rd_ferr_s),
        .rd_ready(rd_ready), .count(count_s), .rx_stall(rx_stall_s),
        .perr_cnt(perr_s), .ferr_cnt(ferr_s), .cnt_clr(cnt_clr)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    // Receiver model: hold a byte until the strobe is seen, then drop r_ready two cycles later.
    task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe,
                             input bit clr = 1'b0);
        int t = 0;
        d_out = d; parity_error = pe; frame_error = fe; r_ready = 1'b1;
        @(negedge clk);
        while (rdn !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(t < 300, 1, "rdn_low_timeout");
        if (t >= 300) begin
            r_ready = 1'b0;
            return;
        end
        if (clr) cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check(rdn, 1, "rdn_single_low_cycle");
        @(negedge clk);
        r_ready = 1'b0; parity_error = 1'b0; frame_error = 1'b0;
        @(negedge clk);
        check(rdn, 1, "rdn_high_after_wait");
        q.push_back({fe, pe, d});
        if (clr) begin
            perr_m = 0; ferr_m = 0; perr_sm = 0; ferr_sm = 0;
        end else begin
            if (pe) begin perr_m = sat_inc(perr_m, 255); perr_sm = sat_inc(perr_sm, 3); end
            if (fe) begin ferr_m = sat_inc(ferr_m, 255); ferr_sm = sat_inc(ferr_sm, 3); end
        end
    endtask

    task automatic pop_one(input string tag);
        logic [9:0] e;
        if (q.size() == 0) begin
            check(rd_valid, 0, {tag, "_empty_valid"});
            return;
        end
        e = q.pop_front();
        check(rd_valid, 1, {tag, "_valid"});
        check(rd_data, e[7:0], {tag, "_data"});
        check(rd_perr, e[8], {tag, "_perr"});
        check(rd_ferr, e[9], {tag, "_ferr"});
        check(rd_valid_s, 1, {tag, "_sat_valid"});
        check({rd_ferr_s, rd_perr_s, rd_data_s}, e, {tag, "_sat_entry"});
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check(perr_cnt, perr_m, {tag, "_perr_cnt"});
        check(ferr_cnt, ferr_m, {tag, "_ferr_cnt"});
        check(perr_s, perr_sm, {tag, "_sat_perr_cnt"});
        check(ferr_s, ferr_sm, {tag, "_sat_ferr_cnt"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        clrn = 1'b0; r_ready = 1'b0; d_out = '0; parity_error = 1'b0;
        frame_error = 1'b0; rd_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        check(rdn, 1, "reset_rdn");
        check(rd_valid, 0, "reset_valid");
        check(count, 0, "reset_count");
        check(rx_stall, 0, "reset_stall");
        check_counters("reset");
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(rdn, 1, "idle_rdn");
            check(rdn_s, 1, "idle_sat_rdn");
            check(rd_valid, 0, "idle_valid");
        end

        // Single byte
        send_byte(8'hA5, 1'b0, 1'b0);
        check(rd_valid, 1, "single_valid");
        check(rd_data, 8'hA5, "single_data");
        check(count, 1, "single_count");
        check(count_s, 1, "single_sat_count");
        pop_one("single_pop");
        check(count, 0, "single_count_after_pop");

        // Fill to DEPTH, then present a 17th byte that must wait
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        check(count, 16, "full_count");
        check(rx_stall, 0, "full_no_stall_idle");
        d_out = 8'h10; r_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check(rdn, 1, "stall_rdn_high");
        end
        check(rx_stall, 1, "stall_flag");
        check(rx_stall_s, 1, "stall_sat_flag");
        check(count, 16, "stall_count");
        pop_one("stall_pop");
        send_byte(8'h10, 1'b0, 1'b0);
        check(count, 16, "refill_count");
        check(rx_stall, 0, "refill_stall_clear");
        while (q.size() != 0) pop_one("drain");
        check(count, 0, "drain_count");

        // Error flags and clear priority
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b1);
        check_counters("err");
        pop_one("err_pop_3c");
        pop_one("err_pop_c3");
        send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
        check_counters("clr_priority");
        pop_one("clr_pop");

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        check_counters("saturate");
        while (q.size() != 0) pop_one("sat_drain");

        // Continuous pops while random bytes stream in, crossing pointer wrap
        for (int i = 0; i < 40; i++) exp_c.push_back(10'($urandom));
        rd_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send_byte(exp_c[i][7:0], exp_c[i][8], exp_c[i][9]);
            end
            begin
                logic [9:0] e;
                int popped = 0;
                int cyc = 0;
                while (popped < 40 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    check(count <= 5'd1, 1, "conc_count_le1");
                    if (rd_valid === 1'b1) begin
                        e = exp_c[popped];
                        check({rd_ferr, rd_perr, rd_data}, e, "conc_entry");
                        popped++;
                    end
                end
                check(popped, 40, "conc_popped");
            end
        join
        rd_ready = 1'b0;
        q.delete();
        @(negedge clk);
        check(count, 0, "conc_final_count");
        check_counters("conc");

        // Reset while READ is in progress
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        check(count, 2, "pre_reset_count");
        d_out = 8'h33; r_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (rdn !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(t < 300, 1, "reset_read_timeout");
        #2 clrn = 1'b0;
        #1;
        check(rdn, 1, "async_reset_rdn");
        check(count, 0, "async_reset_count");
        check(rd_valid, 0, "async_reset_valid");
        q.delete();
        perr_m = 0; ferr_m = 0; perr_sm = 0; ferr_sm = 0;
        check_counters("async_reset");
        r_ready = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check(rdn, 1, "post_reset_rdn");
        send_byte(8'h96, 1'b0, 1'b1);
        check(count, 1, "post_reset_count");
        pop_one("post_reset_pop");
        check_counters("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Sits directly downstream of the UART receiver and drains it autonomously. It issues the receiver's active-low read strobe, captures each byte with its parity/frame error flags, and stores them in a show-ahead FIFO. The CPU pops entries through a valid/ready port. Saturating error counters and an overrun-risk flag support link diagnostics.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width; derived, not overridden
CNT_W, 8, width of each saturating error counter

Ports:
clk16x  in  1  baud-rate x16 clock, the only clock
clrn  in  1  asynchronous active-low reset
r_ready  in  1  receiver holds a byte
d_out  in  8  receiver data byte
parity_error  in  1  receiver parity flag for the current byte
frame_error  in  1  receiver frame flag for the current byte
rdn  out  1  read strobe to receiver, active low
rd_valid  out  1  FIFO head is valid
rd_data  out  8  FIFO head byte
rd_perr  out  1  parity flag of the FIFO head
rd_ferr  out  1  frame flag of the FIFO head
rd_ready  in  1  CPU pop; a pop occurs when rd_valid && rd_ready
count  out  AW+1  current occupancy, 0..DEPTH
rx_stall  out  1  receiver has data but the FIFO is full
perr_cnt  out  CNT_W  saturating count of stored bytes with parity error
ferr_cnt  out  CNT_W  saturating count of stored bytes with frame error
cnt_clr  in  1  synchronous clear of both error counters

Behaviour:
- Reset (clrn=0, asynchronous): rdn=1, state=IDLE, pointers=0, count=0, rd_valid=0, rx_stall=0, perr_cnt=0, ferr_cnt=0. rd_data, rd_perr and rd_ferr are don't-care while rd_valid=0.
- Drain FSM states: IDLE, READ, WAIT.
  - IDLE: if r_ready && count<DEPTH, go to READ. rdn is registered and goes low on that same edge.
  - READ: lasts exactly one cycle with rdn=0. On the closing edge, write {frame_error, parity_error, d_out} at wptr, increment wptr, set rdn=1, go to WAIT.
  - WAIT: stay until r_ready=0, then go to IDLE. This prevents a double read of one byte.
- Throughput is one byte per receiver frame. The minimum IDLE-to-IDLE loop is 3 cycles plus the receiver's r_ready deassert latency.
- rx_stall (registered) = 1 when in IDLE with r_ready=1 and count=DEPTH. The block never drops or overwrites data. The receiver's own overrun behaviour applies while stalled.
- FIFO is show-ahead: rd_data, rd_perr and rd_ferr read combinationally from mem[rptr]. rd_valid = (count!=0).
- Write-to-visible latency is one edge: a byte written at edge t makes rd_valid=1 after edge t.
- Pop: on an edge with rd_valid && rd_ready, increment rptr. rd_ready while empty is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. Full cannot coincide with a push, because the push decision is made in IDLE. The pop during READ is still honoured.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by the count register.
- Error counters:
  - Increment when a write carries parity_error (perr_cnt) or frame_error (ferr_cnt).
  - Both may increment on the same write.
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority over an increment on the same edge: the result is 0.
- Reset mid-operation (including during READ): rdn returns to 1 immediately and FIFO contents are discarded.

Decomposition:
- uart_pkg holds:
  - rx_entry_t, a packed struct {ferr, perr, data[7:0]}
  - the drain FSM state enum {IDLE, READ, WAIT}
  - localparam UART_DATA_W=8
- Sub-module sync_fifo (parameterised on width and depth; push/pop/count, show-ahead read) holds the storage. uart_rx_buffer contains the FSM, the error counters and rx_stall.

Test Plan:
- Reset then idle: r_ready=0 -> rdn=1 constantly, rd_valid=0, count=0, counters 0.
- Single byte: r_ready=1, d_out=8'hA5, no errors, r_ready dropped 2 cycles after the rdn pulse -> exactly one rdn low cycle. After it, rd_valid=1, rd_data=A5, count=1. Pop -> count=0.
- Full/stall (DEPTH=16):
  - 17 bytes 00..10, no pops -> count=16, rx_stall=1, rdn stays 1.
  - Pop once -> rd_data was 00, the 17th byte (10) is read, count returns to 16.
  - Pop all -> 01..10 in order.
- Error flags: byte 3C with parity_error=1, then C3 with frame_error=1 -> rd_perr/rd_ferr match per entry, perr_cnt=1, ferr_cnt=1. Then cnt_clr coinciding with another parity-error write -> perr_cnt=0.
- Saturation (CNT_W=2): 5 parity-error bytes -> perr_cnt=3.
- Concurrency and reset:
  - Continuous rd_ready=1 while bytes arrive -> count never exceeds 1, data in order, across pointer wrap after 40 bytes.
  - Assert clrn=0 during READ -> rdn=1 asynchronously, count=0.
